// File: rtl/flash_pkg.sv
// flash_pkg: shared state type and constants for the flash read controller.
package flash_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;
  localparam int FLASH_ADDR_W = 23;
  localparam logic [3:0] FLASH_BE_ALL = 4'b1111;
endpackage

// File: rtl/flash_read_ctrl_rise_edge_det.sv
// rise_edge_det: registered rising-edge detector, previous value clears to 0 on reset.
module rise_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev_q <= 1'b0;
    else prev_q <= sig;
  assign rise = sig & ~prev_q;
endmodule

// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl: single-word Avalon-MM flash reader with one-deep pending request.
// Optional readdatavalid watchdog enabled by FLASH_READ_TIMEOUT_EN.
module flash_read_ctrl
  import flash_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [31:0]       flash_data,
  output logic              data_valid,
  output logic              busy,
  output logic              rd_err
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
  logic pend_q, pend_d;
  logic [31:0] data_q, data_d;
  logic rise;
  logic timeout;
  rise_edge_det u_req_edge (.clk(clk), .reset_n(reset_n), .sig(rd_req), .rise(rise));
`ifdef FLASH_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign timeout = (state_q == WAIT_DATA) && !flash_mem_readdatavalid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  always_comb begin
    cnt_d = (state_q == ISSUE) ? '0 : (state_q == WAIT_DATA) ? cnt_q + CNT_W'(1) : cnt_q;
    err_d = err_q | timeout;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign rd_err = err_q;
`else
  assign timeout = 1'b0;
  assign rd_err  = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    data_d      = data_q;
    case (state_q)
      IDLE: if (rise || pend_q) begin
        state_d = ISSUE;
        addr_d  = rise ? rd_addr : pend_addr_q;
        pend_d  = 1'b0;
      end
      ISSUE: state_d = flash_mem_waitrequest ? ISSUE : WAIT_DATA;
      WAIT_DATA: if (flash_mem_readdatavalid || timeout) begin
        data_d  = flash_mem_readdatavalid ? flash_mem_readdata : 32'h0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // a newer edge while busy replaces any request already waiting
    if (rise && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_addr_d = rd_addr;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      data_q      <= data_d;
    end
  assign flash_mem_read       = state_q == ISSUE;
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = FLASH_BE_ALL;
  assign flash_data           = data_q;
  assign data_valid           = state_q == DONE;
  assign busy                 = (state_q != IDLE) || pend_q;
endmodule

// File: tb/tb_flash_read_ctrl.sv
// tb_flash_read_ctrl: directed vectors with hand-computed expectations for flash_read_ctrl.
module tb_flash_read_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rd_req = 1'b0;
  logic [22:0] rd_addr = '0;
  logic rd, wreq = 1'b0, rvalid = 1'b0;
  logic [22:0] maddr;
  logic [3:0] be;
  logic [31:0] rdata = '0;
  logic [31:0] fdata;
  logic dv, busy, err;
  int vectors = 0;
  int errors = 0;
  flash_read_ctrl #(.ADDR_W(23), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
    .flash_mem_read(rd), .flash_mem_address(maddr), .flash_mem_byteenable(be),
    .flash_mem_waitrequest(wreq), .flash_mem_readdata(rdata),
    .flash_mem_readdatavalid(rvalid), .flash_data(fdata), .data_valid(dv),
    .busy(busy), .rd_err(err)
  );
  always #10 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    int beats;
    tick();
    tick();
    check("rst_read", {31'b0, rd}, 0);
    check("rst_addr", {9'b0, maddr}, 0);
    check("rst_data", fdata, 0);
    check("rst_dv_busy_err", {29'b0, dv, busy, err}, 0);
    check("byteenable", {28'b0, be}, 32'hF);
    reset_n = 1'b1;
    tick();
    check("idle_no_read", {31'b0, rd}, 0);
    // single read, latency 3
    rd_addr = 23'h00010; rd_req = 1'b1;
    tick();
    check("s_issue", {31'b0, rd}, 1);
    check("s_addr", {9'b0, maddr}, 32'h10);
    check("s_busy", {31'b0, busy}, 1);
    tick();
    check("s_wait_noread", {31'b0, rd}, 0);
    check("s_wait_dv", {31'b0, dv}, 0);
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    check("s_dv", {31'b0, dv}, 1);
    check("s_data", fdata, 32'hDEADBEEF);
    rvalid = 1'b0;
    tick();
    check("s_dv_once", {31'b0, dv}, 0);
    check("s_idle_busy", {31'b0, busy}, 0);
    check("s_hold", fdata, 32'hDEADBEEF);
    rd_req = 1'b0;
    tick();
    // waitrequest stall: 5 stalled cycles, read held 6 cycles, one beat
    rd_addr = 23'h00123; rd_req = 1'b1; wreq = 1'b1; beats = 0;
    tick();
    rd_addr = 23'h00456;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) wreq = 1'b0;
      check("w_read", {31'b0, rd}, 1);
      check("w_addr", {9'b0, maddr}, 32'h123);
      if (rd && !wreq) beats++;
      tick();
    end
    check("w_beats", beats, 1);
    check("w_released", {31'b0, rd}, 0);
    rvalid = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    check("w_dv", {31'b0, dv}, 1);
    check("w_data", fdata, 32'hCAFEF00D);
    rvalid = 1'b0; rd_req = 1'b0;
    tick();
    tick();
    // back-to-back with pending request
    rd_addr = 23'h00200; rd_req = 1'b1;
    tick();
    check("b_addr1", {9'b0, maddr}, 32'h200);
    rd_req = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 23'h7FFFF;
    tick();
    check("b_pend_busy", {31'b0, busy}, 1);
    check("b_pend_noread", {31'b0, rd}, 0);
    rvalid = 1'b1; rdata = 32'h11111111; rd_addr = 23'h0;
    tick();
    check("b_dv1", {31'b0, dv}, 1);
    check("b_data1", fdata, 32'h11111111);
    rvalid = 1'b0;
    tick();
    check("b_gap", {31'b0, dv}, 0);
    tick();
    check("b_read2", {31'b0, rd}, 1);
    check("b_addr2", {9'b0, maddr}, 32'h7FFFF);
    tick();
    rvalid = 1'b1; rdata = 32'h22222222;
    tick();
    check("b_dv2", {31'b0, dv}, 1);
    check("b_data2", fdata, 32'h22222222);
    rvalid = 1'b0;
    tick();
    tick();
    check("b_done_busy", {31'b0, busy}, 0);
    check("b_no_third", {31'b0, rd}, 0);
    // stray readdatavalid while idle
    rvalid = 1'b1; rdata = 32'hBADBAD00;
    tick();
    check("x_data", fdata, 32'h22222222);
    check("x_dv", {31'b0, dv}, 0);
    rvalid = 1'b0; rd_req = 1'b0;
    tick();
    // reset in WAIT_DATA, late readdatavalid ignored
    rd_addr = 23'h00055; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("r_data", fdata, 0);
    check("r_busy", {31'b0, busy}, 0);
    tick();
    reset_n = 1'b1; rvalid = 1'b1; rdata = 32'h12345678;
    tick();
    check("r_late_data", fdata, 0);
    check("r_late_dv", {31'b0, dv}, 0);
    rvalid = 1'b0;
    tick();
    check("r_idle", {30'b0, rd, dv}, 0);
    // rd_req high across reset release yields a request
    reset_n = 1'b0; rd_req = 1'b1; rd_addr = 23'h000AA;
    tick();
    reset_n = 1'b1;
    tick();
    check("rr_read", {31'b0, rd}, 1);
    check("rr_addr", {9'b0, maddr}, 32'hAA);
    tick();
`ifdef FLASH_READ_TIMEOUT_EN
    beats = 0;
    for (int i = 0; i < 40 && !dv; i++) begin
      beats++;
      tick();
    end
    check("t_cycles", beats, 16);
    check("t_dv", {31'b0, dv}, 1);
    check("t_data", fdata, 0);
    tick();
    tick();
    check("t_err_sticky", {31'b0, err}, 1);
`else
    for (int i = 0; i < 20; i++) tick();
    check("nt_wait_forever", {31'b0, busy}, 1);
    check("nt_err", {31'b0, err}, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/flash_read_ctrl.md
FLASH_READ_CTRL -- requirements
Module: flash_read_ctrl

Interface
REQ-001 Parameter ADDR_W, default 23, flash word-address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, readdatavalid watchdog limit (TIMEOUT_EN only).
REQ-003 clk  input  1  50 MHz system clock; the only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rd_req  input  1  level request from address counter; rising edge starts one word read.
REQ-006 rd_addr  input  ADDR_W  word address, sampled on accepted rd_req rising edge.
REQ-007 flash_mem_read  output  1  Avalon-MM read strobe.
REQ-008 flash_mem_address  output  ADDR_W  Avalon-MM word address.
REQ-009 flash_mem_byteenable  output  4  Avalon-MM byte enables.
REQ-010 flash_mem_waitrequest  input  1  slave stall.
REQ-011 flash_mem_readdata  input  32  read data.
REQ-012 flash_mem_readdatavalid  input  1  read data qualifier.
REQ-013 flash_data  output  32  last word read, held stable until next completion.
REQ-014 data_valid  output  1  one-cycle pulse when flash_data updates.
REQ-015 busy  output  1  high from request acceptance through data_valid cycle.
REQ-016 rd_err  output  1  sticky timeout flag (constant 0 without TIMEOUT_EN).

Function
REQ-017 States: IDLE, ISSUE, WAIT_DATA, DONE.
REQ-018 rd_req edge detect: registered previous value; edge = rd_req & ~rd_req_d.
REQ-019 IDLE: on edge or pending flag, latch rd_addr (or pending address) and go ISSUE next cycle.
REQ-020 ISSUE: flash_mem_read=1, address driven from latch; held while waitrequest=1; on waitrequest=0 go WAIT_DATA.
REQ-021 WAIT_DATA: flash_mem_read=0; on readdatavalid=1 capture readdata into flash_data, go DONE.
REQ-022 DONE: data_valid=1 for exactly this cycle, then IDLE.
REQ-023 Latency with zero waitrequest and readdatavalid one cycle after accept: data_valid 3 cycles after rd_req edge.
REQ-024 flash_mem_byteenable constant 4'b1111.
REQ-025 Edge arriving while busy: captured as single pending request (address latched then); further edges while pending overwrite pending address.
REQ-026 Pending request served immediately from DONE->IDLE->ISSUE without needing a new edge.
REQ-027 readdatavalid seen outside WAIT_DATA ignored; flash_data unchanged.
REQ-028 flash_mem_read never asserted outside ISSUE.

Reset
REQ-029 reset_n low: state IDLE, flash_mem_read=0, flash_mem_address=0, flash_data=0, data_valid=0, busy=0, rd_err=0, pending cleared, rd_req_d=0.
REQ-030 Reset mid-read aborts transaction; late readdatavalid after release ignored (state IDLE).
REQ-031 rd_req already high at reset release produces an edge one cycle after release (rd_req_d reset 0).

Configuration
REQ-032 Macro FLASH_READ_TIMEOUT_EN defined: counter clears on ISSUE->WAIT_DATA, counts in WAIT_DATA; at TIMEOUT_CYCLES flash_data=32'h0000_0000, rd_err set, go DONE (data_valid pulses).
REQ-033 Macro undefined: no counter, WAIT_DATA waits indefinitely, rd_err tied 0.

Structure
REQ-034 Shared package flash_pkg: state enum type, FLASH_ADDR_W=23, FLASH_BE_ALL=4'b1111.
REQ-035 Sub-module rise_edge_det (registered rising-edge detector, async active-low reset) instanced for rd_req.

Verification
REQ-036 Single read: rd_addr=23'h00010, slave returns 32'hDEADBEEF one cycle after accept, no wait -> flash_data=32'hDEADBEEF, data_valid 1 cycle, latency 3.
REQ-037 Waitrequest stall: waitrequest high 5 cycles -> flash_mem_read and address held constant 6 cycles, single read beat.
REQ-038 Back-to-back: second edge (addr 23'h7FFFF) during WAIT_DATA of first -> two data_valid pulses, second read issued to 23'h7FFFF with no new edge.
REQ-039 Reset mid-read: reset_n low in WAIT_DATA, readdatavalid arrives after release -> flash_data=0, no data_valid.
REQ-040 Timeout (FLASH_READ_TIMEOUT_EN, TIMEOUT_CYCLES=16): no readdatavalid -> data_valid at count 16, flash_data=0, rd_err=1 until reset.
